// File: rtl/vid_tile_fetch.sv
// Tile-mode front end: beam position + scroll -> tile map address -> char RAM video port.
// Latency: map_addr registered; vp_*_0 one cycle after vp_active; pix_pal_4/pix_valid_4 four cycles after.
// Backpressure: none, the pipe runs freely and vp_active gaps become valid=0 bubbles.
//
// Ports:
//   vp_clk, vp_rst_n                       video clock, async active-low reset
//   vp_frame_start/vp_line_start/vp_active beam timing strobes
//   cfg_scroll_x/cfg_scroll_y              scroll in pixels/lines, taken at frame start
//   map_addr/map_rdata                     tile map RAM port {ty, tx}, 1-cycle sync read
//   vp_char_0..vp_dbl_0                    char RAM request for the current pixel
//   pix_pal_4/pix_valid_4                  palette/valid aligned with char RAM pixel data
module vid_tile_fetch #(
  parameter int TX_LOG2 = 6,
  parameter int TY_LOG2 = 5
) (
  input  logic                       vp_clk,
  input  logic                       vp_rst_n,
  input  logic                       vp_frame_start,
  input  logic                       vp_line_start,
  input  logic                       vp_active,
  input  logic [TX_LOG2+2:0]         cfg_scroll_x,
  input  logic [TY_LOG2+2:0]         cfg_scroll_y,
  output logic [TX_LOG2+TY_LOG2-1:0] map_addr,
  input  logic [15:0]                map_rdata,
  output logic [6:0]                 vp_char_0,
  output logic [2:0]                 vp_x_0,
  output logic [2:0]                 vp_y_0,
  output logic                       vp_mx_0,
  output logic                       vp_my_0,
  output logic                       vp_rot_0,
  output logic                       vp_dbl_0,
  output logic [3:0]                 pix_pal_4,
  output logic                       pix_valid_4
);

  localparam int PXW = TX_LOG2 + 3;
  localparam int LYW = TY_LOG2 + 3;
  localparam logic [PXW-1:0] PX_ONE = 1;
  localparam logic [LYW-1:0] LY_ONE = 1;

  logic [PXW-1:0] sx_s;   // X scroll shadow, only changes at frame start
  logic [PXW-1:0] px;
  logic [LYW-1:0] ly;
  logic           first;  // next line_start begins the first line, ly already loaded

  logic           a1;
  logic [2:0]     x1;
  logic [2:0]     y1;
  logic           v2, v3, v4;
  logic [3:0]     p2, p3, p4;
  logic           vis1;

  // Beam position. The vertical scroll is applied straight from cfg at frame
  // start, so no separate Y shadow is needed. A line_start in the same cycle
  // as frame_start is the first line: ly stays at the scroll value.
  always_ff @(posedge vp_clk or negedge vp_rst_n) begin
    if (!vp_rst_n) begin
      sx_s  <= '0;
      px    <= '0;
      ly    <= '0;
      first <= 1'b0;
    end else begin
      if (vp_frame_start) begin
        sx_s  <= cfg_scroll_x;
        ly    <= cfg_scroll_y;
        first <= ~vp_line_start;
      end else if (vp_line_start) begin
        if (first) first <= 1'b0;
        else       ly    <= ly + LY_ONE;
      end

      if (vp_line_start)  px <= vp_frame_start ? cfg_scroll_x : sx_s;
      else if (vp_active) px <= px + PX_ONE;
    end
  end

  // Counters wrap naturally, so the map wraps in both directions.
  assign map_addr = {ly[LYW-1:3], px[PXW-1:3]};

  assign vis1 = a1 & ~map_rdata[15];

  // Stage 1 lines up with the map RAM read data; stages 2..4 cover the
  // char RAM read so palette/valid meet the pixel bits downstream.
  always_ff @(posedge vp_clk or negedge vp_rst_n) begin
    if (!vp_rst_n) begin
      a1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
      p2 <= '0;
      p3 <= '0;
      p4 <= '0;
    end else begin
      a1 <= vp_active;
      x1 <= px[2:0];
      y1 <= ly[2:0];
      v2 <= vis1;
      p2 <= vis1 ? map_rdata[14:11] : 4'd0;
      v3 <= v2;
      p3 <= p2;
      v4 <= v3;
      p4 <= p3;
    end
  end

  assign vp_char_0   = a1 ? map_rdata[6:0] : 7'd0;
  assign vp_mx_0     = a1 & map_rdata[7];
  assign vp_my_0     = a1 & map_rdata[8];
  assign vp_rot_0    = a1 & map_rdata[9];
  assign vp_dbl_0    = a1 & map_rdata[10];
  assign vp_x_0      = a1 ? x1 : 3'd0;
  assign vp_y_0      = a1 ? y1 : 3'd0;
  assign pix_valid_4 = v4;
  assign pix_pal_4   = p4;

endmodule
